// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: decode-side instruction fields, forwarding sources,
// pipeline control and E-stage results of the ID/EX operand stage.
//   master : drives decode fields, forwarding sources, iStall/iFlush; reads E outputs
//   slave  : the operand stage itself
interface ex_operand_stage_if;
   // decode stage
   logic        iValidD;
   logic [4:0]  iRsD, iRtD, iRdD;
   logic [31:0] iRsValD, iRtValD;
   logic [31:0] iImmD;
   logic [4:0]  iShamtD;
   logic        iASelD, iBSelD;
   logic [5:0]  iALUFunD;
   logic        iSignD;
   logic        iRegWrD, iMemRdD, iMemWrD;
   // forwarding sources
   logic        iRegWrM;
   logic [4:0]  iRdM;
   logic [31:0] iResultM;
   logic        iRegWrW;
   logic [4:0]  iRdW;
   logic [31:0] iResultW;
   // pipeline control
   logic        iStall, iFlush;
   // E-stage results
   logic        oStallD;
   logic [31:0] oA, oB;
   logic [5:0]  oALUFun;
   logic        oSign;
   logic        oValidE, oRegWrE, oMemRdE, oMemWrE;
   logic [4:0]  oRdE;
   logic [31:0] oStoreDataE;

   modport master (
      output iValidD, iRsD, iRtD, iRdD, iRsValD, iRtValD, iImmD, iShamtD,
             iASelD, iBSelD, iALUFunD, iSignD, iRegWrD, iMemRdD, iMemWrD,
             iRegWrM, iRdM, iResultM, iRegWrW, iRdW, iResultW, iStall, iFlush,
      input  oStallD, oA, oB, oALUFun, oSign, oValidE, oRegWrE, oMemRdE,
             oMemWrE, oRdE, oStoreDataE
   );

   modport slave (
      input  iValidD, iRsD, iRtD, iRdD, iRsValD, iRtValD, iImmD, iShamtD,
             iASelD, iBSelD, iALUFunD, iSignD, iRegWrD, iMemRdD, iMemWrD,
             iRegWrM, iRdM, iResultM, iRegWrW, iRdW, iResultW, iStall, iFlush,
      output oStallD, oA, oB, oALUFun, oSign, oValidE, oRegWrE, oMemRdE,
             oMemWrE, oRdE, oStoreDataE
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register of the five-stage MIPS core. Captures the
// decoded instruction (with MEM/WB capture bypass), selects ALU operands with
// EX/MEM and MEM/WB forwarding, and detects load-use hazards.
//   iClk  : rising-edge clock
//   iRst  : synchronous active-high reset
//   bus   : slave side of ex_operand_stage_if (decode fields, forwarding
//           sources, iStall/iFlush in; operands, E flags, oStallD out)
module ex_operand_stage (
   input  logic               iClk,
   input  logic               iRst,
   ex_operand_stage_if.slave  bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned FW = 6;

   logic          validE;
   logic [RW-1:0] rsE, rtE, rdE, shamtE;
   logic [DW-1:0] rsValE, rtValE, immE;
   logic          aSelE, bSelE;
   logic [FW-1:0] aluFunE;
   logic          signE, regWrE, memRdE, memWrE;

   logic [DW-1:0] capRs, capRt, fwdRs, fwdRt;
   logic          hazard;

   // A write to register 0 is discarded, so it never matches a source.
   function automatic logic hit(input logic wr, input logic [RW-1:0] dst,
                                input logic [RW-1:0] src);
      return wr && (dst != RW'(0)) && (dst == src);
   endfunction

   // Capture bypass: WB writes the RF in the same cycle decode reads it.
   always_comb begin
      capRs = bus.iRsValD;
      capRt = bus.iRtValD;
      if (hit(bus.iRegWrW, bus.iRdW, bus.iRsD)) capRs = bus.iResultW;
      if (hit(bus.iRegWrW, bus.iRdW, bus.iRtD)) capRt = bus.iResultW;
   end

   // Operand forwarding, MEM has priority over WB (it is the younger write).
   always_comb begin
      fwdRs = rsValE;
      fwdRt = rtValE;
      if (hit(bus.iRegWrM, bus.iRdM, rsE))      fwdRs = bus.iResultM;
      else if (hit(bus.iRegWrW, bus.iRdW, rsE)) fwdRs = bus.iResultW;
      if (hit(bus.iRegWrM, bus.iRdM, rtE))      fwdRt = bus.iResultM;
      else if (hit(bus.iRegWrW, bus.iRdW, rtE)) fwdRt = bus.iResultW;
   end

   // Load in E feeding the instruction in D cannot be forwarded in time.
   always_comb begin
      hazard = validE && memRdE && bus.iValidD &&
               (hit(1'b1, rdE, bus.iRsD) || hit(1'b1, rdE, bus.iRtD));
   end

   // E register: reset > flush > stall (hold) > hazard bubble > capture.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         validE  <= 1'b0;
         rsE     <= '0;
         rtE     <= '0;
         rdE     <= '0;
         shamtE  <= '0;
         rsValE  <= '0;
         rtValE  <= '0;
         immE    <= '0;
         aSelE   <= 1'b0;
         bSelE   <= 1'b0;
         aluFunE <= '0;
         signE   <= 1'b0;
         regWrE  <= 1'b0;
         memRdE  <= 1'b0;
         memWrE  <= 1'b0;
      end else if (bus.iFlush) begin
         validE <= 1'b0;
      end else if (!bus.iStall) begin
         if (hazard) begin
            validE <= 1'b0;
         end else begin
            validE  <= bus.iValidD;
            rsE     <= bus.iRsD;
            rtE     <= bus.iRtD;
            rdE     <= bus.iRdD;
            shamtE  <= bus.iShamtD;
            rsValE  <= capRs;
            rtValE  <= capRt;
            immE    <= bus.iImmD;
            aSelE   <= bus.iASelD;
            bSelE   <= bus.iBSelD;
            aluFunE <= bus.iALUFunD;
            signE   <= bus.iSignD;
            regWrE  <= bus.iRegWrD;
            memRdE  <= bus.iMemRdD;
            memWrE  <= bus.iMemWrD;
         end
      end
   end

   assign bus.oA          = aSelE ? {(DW-RW)'(0), shamtE} : fwdRs;
   assign bus.oB          = bSelE ? immE : fwdRt;
   assign bus.oStoreDataE = fwdRt;
   assign bus.oALUFun     = aluFunE;
   assign bus.oSign       = signE;
   assign bus.oValidE     = validE;
   assign bus.oRegWrE     = validE & regWrE;
   assign bus.oMemRdE     = validE & memRdE;
   assign bus.oMemWrE     = validE & memWrE;
   assign bus.oRdE        = rdE;
   assign bus.oStallD     = hazard;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized + directed scoreboard bench for ex_operand_stage.
module tb_ex_operand_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_operand_stage_if bus ();
   ex_operand_stage dut (.iClk(clk), .iRst(rst), .bus(bus));

   localparam logic [5:0] ADD = 6'b000000;
   localparam logic [5:0] SLL = 6'b100000;

   typedef struct {
      bit rst, stall, flush, validD;
      logic [4:0] rs, rt, rd, shamt;
      logic [31:0] rsVal, rtVal, imm;
      bit aSel, bSel, sign, regWr, memRd, memWr;
      logic [5:0] fun;
      bit regWrM; logic [4:0] rdM; logic [31:0] resM;
      bit regWrW; logic [4:0] rdW; logic [31:0] resW;
   } stim_t;

   // Instruction currently in E, as the pipeline sees it.
   typedef struct {
      bit valid, known;
      logic [4:0] rs, rt, rd, shamt;
      logic [31:0] rsVal, rtVal, imm;
      bit aSel, bSel, sign, regWr, memRd, memWr;
      logic [5:0] fun;
   } inst_t;

   typedef struct {
      logic [31:0] a, b, sd;
      logic [5:0] fun;
      logic [4:0] rd;
      bit sign, valid, rw, mr, mw, stall, known;
   } exp_t;

   stim_t cur;
   inst_t e;
   exp_t  q[$];
   int checks = 0;
   int errors = 0;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   // Value a source register really holds given in-flight writes.
   function automatic logic [31:0] srcVal(input logic [4:0] r, input logic [31:0] held);
      if (r == 5'd0) return held;
      if (cur.regWrM && cur.rdM == r) return cur.resM;
      if (cur.regWrW && cur.rdW == r) return cur.resW;
      return held;
   endfunction

   function automatic bit loadUse();
      return e.valid && e.memRd && cur.validD && e.rd != 5'd0 &&
             (e.rd == cur.rs || e.rd == cur.rt);
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t randStim();
      stim_t s;
      s.rst = ($urandom_range(0, 49) == 0);
      s.stall = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.validD = $urandom_range(0, 1) == 1;
      s.rs = 5'($urandom_range(0, 7));
      s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7));
      s.shamt = 5'($urandom);
      s.rsVal = $urandom; s.rtVal = $urandom; s.imm = $urandom;
      s.aSel = ($urandom_range(0, 3) == 0);
      s.bSel = $urandom_range(0, 1) == 1;
      s.sign = $urandom_range(0, 1) == 1;
      s.regWr = $urandom_range(0, 1) == 1;
      s.memRd = ($urandom_range(0, 2) == 0);
      s.memWr = ($urandom_range(0, 3) == 0);
      s.fun = 6'($urandom);
      s.regWrM = $urandom_range(0, 1) == 1;
      s.rdM = 5'($urandom_range(0, 7));
      s.resM = $urandom;
      s.regWrW = $urandom_range(0, 1) == 1;
      s.rdW = 5'($urandom_range(0, 7));
      s.resW = $urandom;
      return s;
   endfunction

   // Drive one cycle of inputs, queue the expected outputs, stop just past negedge.
   task automatic drive(input stim_t s, input bit push);
      exp_t x;
      cur = s;
      rst = s.rst;
      bus.iStall = s.stall; bus.iFlush = s.flush; bus.iValidD = s.validD;
      bus.iRsD = s.rs; bus.iRtD = s.rt; bus.iRdD = s.rd; bus.iShamtD = s.shamt;
      bus.iRsValD = s.rsVal; bus.iRtValD = s.rtVal; bus.iImmD = s.imm;
      bus.iASelD = s.aSel; bus.iBSelD = s.bSel; bus.iSignD = s.sign;
      bus.iALUFunD = s.fun; bus.iRegWrD = s.regWr; bus.iMemRdD = s.memRd;
      bus.iMemWrD = s.memWr;
      bus.iRegWrM = s.regWrM; bus.iRdM = s.rdM; bus.iResultM = s.resM;
      bus.iRegWrW = s.regWrW; bus.iRdW = s.rdW; bus.iResultW = s.resW;
      if (push) begin
         x.sd = srcVal(e.rt, e.rtVal);
         x.a = e.aSel ? {27'd0, e.shamt} : srcVal(e.rs, e.rsVal);
         x.b = e.bSel ? e.imm : x.sd;
         x.fun = e.fun; x.rd = e.rd; x.sign = e.sign;
         x.valid = e.valid;
         x.rw = e.valid && e.regWr;
         x.mr = e.valid && e.memRd;
         x.mw = e.valid && e.memWr;
         x.stall = loadUse();
         x.known = e.known;
         q.push_back(x);
      end
      @(negedge clk);
      #1;
   endtask

   // Clock edge: advance the reference pipeline by one step.
   task automatic tick();
      @(posedge clk);
      if (cur.rst) begin
         e = '{default: '0};
         e.known = 1'b1;
      end else if (cur.flush) begin
         e.valid = 1'b0; e.known = 1'b0;
      end else if (cur.stall) begin
         // frozen
      end else if (loadUse()) begin
         e.valid = 1'b0; e.known = 1'b0;
      end else begin
         e.valid = cur.validD; e.known = 1'b1;
         e.rs = cur.rs; e.rt = cur.rt; e.rd = cur.rd; e.shamt = cur.shamt;
         e.rsVal = (cur.regWrW && cur.rdW != 5'd0 && cur.rdW == cur.rs) ? cur.resW : cur.rsVal;
         e.rtVal = (cur.regWrW && cur.rdW != 5'd0 && cur.rdW == cur.rt) ? cur.resW : cur.rtVal;
         e.imm = cur.imm; e.aSel = cur.aSel; e.bSel = cur.bSel; e.sign = cur.sign;
         e.fun = cur.fun; e.regWr = cur.regWr; e.memRd = cur.memRd; e.memWr = cur.memWr;
      end
      #1;
   endtask

   // Monitor: compare every presented E-stage cycle against the queue.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            cmp("valid", 32'(bus.oValidE), 32'(x.valid));
            cmp("regWr", 32'(bus.oRegWrE), 32'(x.rw));
            cmp("memRd", 32'(bus.oMemRdE), 32'(x.mr));
            cmp("memWr", 32'(bus.oMemWrE), 32'(x.mw));
            cmp("stallD", 32'(bus.oStallD), 32'(x.stall));
            if (x.known) begin
               cmp("oA", bus.oA, x.a);
               cmp("oB", bus.oB, x.b);
               cmp("store", bus.oStoreDataE, x.sd);
               cmp("fun", 32'(bus.oALUFun), 32'(x.fun));
               cmp("sign", 32'(bus.oSign), 32'(x.sign));
               cmp("rd", 32'(bus.oRdE), 32'(x.rd));
            end
         end
      end
   end

   initial begin
      stim_t s;
      e = '{default: '0};
      rst = 1'b1;
      @(posedge clk);
      #1;

      // reset for two cycles with random inputs
      s = randStim(); s.rst = 1; drive(s, 0); tick();
      s = randStim(); s.rst = 1; drive(s, 1);
      cmp("rst_oA", bus.oA, 32'd0);
      cmp("rst_oB", bus.oB, 32'd0);
      cmp("rst_fun", 32'(bus.oALUFun), 32'(ADD));
      cmp("rst_valid", 32'(bus.oValidE), 32'd0);
      cmp("rst_stallD", 32'(bus.oStallD), 32'd0);
      cmp("rst_store", bus.oStoreDataE, 32'd0);
      tick();

      // forwarding priority: M over W over captured value
      s = idle(); s.validD = 1; s.rs = 5; s.rsVal = 32'h5555; s.regWr = 1; s.rd = 6;
      drive(s, 1); tick();
      s = idle(); s.stall = 1;
      s.regWrM = 1; s.rdM = 5; s.resM = 32'h11;
      s.regWrW = 1; s.rdW = 5; s.resW = 32'h22;
      drive(s, 1); cmp("fwd_M", bus.oA, 32'h11); tick();
      s.regWrM = 0;
      drive(s, 1); cmp("fwd_W", bus.oA, 32'h22); tick();
      s = idle(); s.validD = 1; s.rs = 0; s.rsVal = 0;
      drive(s, 1); tick();
      s = idle(); s.stall = 1;
      s.regWrM = 1; s.rdM = 0; s.resM = 32'h33;
      s.regWrW = 1; s.rdW = 0; s.resW = 32'h44;
      drive(s, 1); cmp("fwd_r0", bus.oA, 32'd0); tick();

      // shift operands
      s = idle(); s.validD = 1; s.aSel = 1; s.shamt = 7; s.rt = 3; s.rtVal = 32'h80;
      s.fun = SLL; s.regWr = 1; s.rd = 2;
      drive(s, 1); tick();
      s = idle(); s.stall = 1;
      drive(s, 1);
      cmp("sll_oA", bus.oA, 32'd7);
      cmp("sll_oB", bus.oB, 32'h80);
      cmp("sll_fun", 32'(bus.oALUFun), 32'(SLL));
      tick();

      // load-use: lw $4 in E, add using $4 in D
      s = idle(); s.validD = 1; s.memRd = 1; s.regWr = 1; s.rd = 4; s.rs = 1;
      s.bSel = 1; s.imm = 8;
      drive(s, 1); tick();
      s = idle(); s.validD = 1; s.rs = 4; s.rt = 2; s.rtVal = 32'h2; s.rsVal = 32'hDEAD;
      s.regWr = 1; s.rd = 5; s.fun = ADD;
      drive(s, 1); cmp("lu_stallD", 32'(bus.oStallD), 32'd1); tick();
      s.regWrM = 1; s.rdM = 4; s.resM = 32'h1234;
      drive(s, 1);
      cmp("lu_bubble", 32'(bus.oValidE), 32'd0);
      cmp("lu_once", 32'(bus.oStallD), 32'd0);
      tick();
      s = idle(); s.stall = 1; s.regWrM = 1; s.rdM = 4; s.resM = 32'h1234;
      drive(s, 1);
      cmp("lu_fwd", bus.oA, 32'h1234);
      cmp("lu_valid", 32'(bus.oValidE), 32'd1);
      tick();

      // stall holds E for three cycles while D churns
      s = idle(); s.validD = 1; s.rs = 1; s.rsVal = 32'hCAFE; s.rt = 2; s.rtVal = 32'hBEEF;
      s.regWr = 1; s.rd = 3;
      drive(s, 1); tick();
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.stall = 1; s.validD = 1; s.rs = 5'(i + 4); s.rsVal = $urandom;
         drive(s, 1);
         cmp("stall_oA", bus.oA, 32'hCAFE);
         cmp("stall_oB", bus.oB, 32'hBEEF);
         cmp("stall_rd", 32'(bus.oRdE), 32'd3);
         cmp("stall_valid", 32'(bus.oValidE), 32'd1);
         tick();
      end
      s = idle(); s.stall = 1; s.flush = 1; s.validD = 1; s.regWr = 1;
      drive(s, 1); tick();
      s = idle(); s.stall = 1;
      drive(s, 1);
      cmp("flush_valid", 32'(bus.oValidE), 32'd0);
      cmp("flush_regWr", 32'(bus.oRegWrE), 32'd0);
      tick();

      // capture bypass from WB
      s = idle(); s.validD = 1; s.rs = 9; s.rsVal = 32'h1; s.regWr = 1; s.rd = 10;
      s.regWrW = 1; s.rdW = 9; s.resW = 32'hABCD;
      drive(s, 1); tick();
      s = idle(); s.stall = 1;
      drive(s, 1); cmp("cap_bypass", bus.oA, 32'hABCD); tick();

      // reset mid-hazard empties the stage
      s = idle(); s.validD = 1; s.memRd = 1; s.regWr = 1; s.rd = 4;
      drive(s, 1); tick();
      s = idle(); s.validD = 1; s.rs = 4; s.rst = 1;
      drive(s, 1); tick();
      s = idle(); s.validD = 1; s.rs = 4;
      drive(s, 1);
      cmp("rst_hazard_valid", 32'(bus.oValidE), 32'd0);
      cmp("rst_hazard_stall", 32'(bus.oStallD), 32'd0);
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         s = randStim();
         drive(s, 1);
         tick();
      end

      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
